// File: rtl/core_imem_responder.sv
// Fetch-port responder: serves instruction words from a local RAM, with a debug byte-write port for loading.
// Latency: ack LATENCY enabled edges after acceptance; one fetch per LATENCY+1 enabled cycles sustained.
// Backpressure: o_stall high while a fetch is outstanding; requests seen while BUSY or colliding with a debug write wait.
module core_imem_responder #(
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              LATENCY     = 2,
    parameter logic [AW-1:0]   BASE_ADDR   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    output logic              o_stall,
    input  logic              i_fetch_read,
    input  logic [AW-1:0]     i_fetch_addr,
    output logic [DW-1:0]     o_fetch_data,
    output logic              o_fetch_ack,
    output logic              o_fetch_err,
    input  logic              i_debug_write,
    input  logic [AW-1:0]     i_w_debug_addr,
    input  logic [DW/8-1:0]   i_w_debug_byte_en,
    input  logic [DW-1:0]     i_w_debug_data
);

    localparam int            IW      = $clog2(DEPTH_WORDS);
    localparam int            NB      = DW / 8;
    localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH_WORDS);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic [IW-1:0]   idx_q;
    logic            err_q;
    logic            accept;
    logic            done;
    logic [DW-1:0]   mem [DEPTH_WORDS];

    // Out of range covers both addresses below the base and past the last word.
    function automatic logic addr_bad(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((off >> 2) >= DEPTH_L) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [AW-1:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else if (i_clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_fetch_read && !i_debug_write) begin
                    state_d = BUSY;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_stall = (state_q == BUSY);
    end

    // Response path reads mem before this edge's debug write lands (read-before-write).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            o_fetch_ack  <= 1'b0;
            o_fetch_err  <= 1'b0;
            o_fetch_data <= '0;
        end else if (i_clk_en) begin
            o_fetch_ack <= done;
            o_fetch_err <= done & err_q;
            if (accept) begin
                cnt_q <= 4'(LATENCY - 1);
                idx_q <= addr_idx(i_fetch_addr);
                err_q <= addr_bad(i_fetch_addr);
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done) begin
                o_fetch_data <= err_q ? '0 : mem[idx_q];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en && i_debug_write && !addr_bad(i_w_debug_addr)) begin
            for (int b = 0; b < NB; b++) begin
                if (i_w_debug_byte_en[b]) begin
                    mem[addr_idx(i_w_debug_addr)][8*b +: 8] <= i_w_debug_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_core_imem_responder.sv
// Directed bench for core_imem_responder: latency, back-to-back, errors, write collision, clock enable, reset abort.
module tb_core_imem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_clk_en = 1'b1;
    logic            o_stall;
    logic            i_fetch_read = 1'b0;
    logic [AW-1:0]   i_fetch_addr = '0;
    logic [DW-1:0]   o_fetch_data;
    logic            o_fetch_ack;
    logic            o_fetch_err;
    logic            i_debug_write = 1'b0;
    logic [AW-1:0]   i_w_debug_addr = '0;
    logic [DW/8-1:0] i_w_debug_byte_en = '0;
    logic [DW-1:0]   i_w_debug_data = '0;

    int checks   = 0;
    int failures = 0;

    core_imem_responder #(
        .AW(AW), .DW(DW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR('0)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clk_en(i_clk_en),
        .o_stall(o_stall),
        .i_fetch_read(i_fetch_read),
        .i_fetch_addr(i_fetch_addr),
        .o_fetch_data(o_fetch_data),
        .o_fetch_ack(o_fetch_ack),
        .o_fetch_err(o_fetch_err),
        .i_debug_write(i_debug_write),
        .i_w_debug_addr(i_w_debug_addr),
        .i_w_debug_byte_en(i_w_debug_byte_en),
        .i_w_debug_data(i_w_debug_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic dbg_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        i_debug_write     = 1'b1;
        i_w_debug_addr    = a;
        i_w_debug_byte_en = be;
        i_w_debug_data    = d;
        step();
        i_debug_write     = 1'b0;
    endtask

    // Counts edges until ack (bounded) and the cycles o_stall was seen high on the way.
    task automatic wait_ack(output int n, output int stl);
        n   = 0;
        stl = 0;
        while (o_fetch_ack !== 1'b1 && n < 40) begin
            if (o_stall) stl++;
            step();
            n++;
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string tag);
        int n, stl;
        i_fetch_read = 1'b1;
        i_fetch_addr = a;
        step();
        i_fetch_read = 1'b0;
        wait_ack(n, stl);
        check({tag, "_lat"}, n, LAT);
        check({tag, "_stall_cycles"}, stl, LAT);
        check({tag, "_stall_at_ack"}, {31'd0, o_stall}, 0);
        check({tag, "_data"}, o_fetch_data, ed);
        check({tag, "_err"}, {31'd0, o_fetch_err}, {31'd0, ee});
        step();
        check({tag, "_ack_pulse"}, {31'd0, o_fetch_ack}, 0);
        check({tag, "_err_pulse"}, {31'd0, o_fetch_err}, 0);
        check({tag, "_data_hold"}, o_fetch_data, ed);
    endtask

    initial begin
        int n, stl, cyc, last, got, extra;

        step();
        step();
        check("rst_ack", {31'd0, o_fetch_ack}, 0);
        check("rst_err", {31'd0, o_fetch_err}, 0);
        check("rst_data", o_fetch_data, 0);
        check("rst_stall", {31'd0, o_stall}, 0);
        i_rst = 1'b0;
        step();

        dbg_wr(32'h0, 4'hF, 32'h0000_0013);
        do_fetch(32'h0, 32'h0000_0013, 1'b0, "basic");

        dbg_wr(32'h10, 4'hF, 32'd1);
        dbg_wr(32'h14, 4'hF, 32'd2);
        dbg_wr(32'h18, 4'hF, 32'd3);
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h10;
        cyc  = 0;
        last = 0;
        got  = 0;
        for (int k = 0; k < 30 && got < 3; k++) begin
            step();
            cyc++;
            if (o_fetch_ack) begin
                check($sformatf("b2b_data%0d", got), o_fetch_data, got + 1);
                if (got == 0) check("b2b_first", cyc, LAT + 1);
                else          check($sformatf("b2b_spacing%0d", got), cyc - last, LAT + 1);
                last = cyc;
                got++;
                i_fetch_addr = i_fetch_addr + 32'd4;
                if (got == 3) i_fetch_read = 1'b0;
            end
        end
        check("b2b_count", got, 3);
        extra = 0;
        for (int k = 0; k < 2 * (LAT + 1); k++) begin
            step();
            if (o_fetch_ack) extra++;
        end
        check("b2b_no_extra", extra, 0);

        do_fetch(32'h2, 32'h0, 1'b1, "misal");
        do_fetch(DEPTH * 4, 32'h0, 1'b1, "oob");

        dbg_wr(32'h20, 4'hF, 32'h1111_1111);
        i_fetch_read      = 1'b1;
        i_fetch_addr      = 32'h20;
        i_debug_write     = 1'b1;
        i_w_debug_addr    = 32'h20;
        i_w_debug_byte_en = 4'b0010;
        i_w_debug_data    = 32'hAABB_CCDD;
        step();
        i_debug_write = 1'b0;
        check("coll_not_accepted", {31'd0, o_stall}, 0);
        step();
        i_fetch_read = 1'b0;
        check("coll_accepted", {31'd0, o_stall}, 1);
        wait_ack(n, stl);
        check("coll_lat", n, LAT);
        check("coll_data", o_fetch_data, 32'h1111_CC11);
        step();

        dbg_wr(32'h30, 4'hF, 32'hCAFE_F00D);
        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h30;
        step();
        i_fetch_read = 1'b0;
        for (int k = 0; k < LAT - 1; k++) step();
        dbg_wr(32'h30, 4'hF, 32'h1234_5678);
        check("rbw_ack", {31'd0, o_fetch_ack}, 1);
        check("rbw_old_data", o_fetch_data, 32'hCAFE_F00D);
        step();
        do_fetch(32'h30, 32'h1234_5678, 1'b0, "rbw_new");

        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h10;
        step();
        i_fetch_read = 1'b0;
        i_clk_en = 1'b0; step();
        i_clk_en = 1'b1; step();
        i_clk_en = 1'b0; step();
        check("ce_no_early_ack", {31'd0, o_fetch_ack}, 0);
        check("ce_stall", {31'd0, o_stall}, 1);
        i_clk_en = 1'b1; step();
        check("ce_ack", {31'd0, o_fetch_ack}, 1);
        check("ce_data", o_fetch_data, 32'd1);
        i_clk_en = 1'b0; step(); step();
        check("ce_ack_held", {31'd0, o_fetch_ack}, 1);
        check("ce_data_held", o_fetch_data, 32'd1);
        i_clk_en = 1'b1; step();
        check("ce_ack_clear", {31'd0, o_fetch_ack}, 0);

        i_fetch_read = 1'b1;
        i_fetch_addr = 32'h14;
        step();
        i_fetch_read = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("abort_stall", {31'd0, o_stall}, 0);
        check("abort_data", o_fetch_data, 0);
        extra = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            step();
            if (o_fetch_ack) extra++;
        end
        check("abort_no_ack", extra, 0);
        check("abort_idle", {31'd0, o_stall}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
